// File: rtl/sm_arith_pkg.sv
// Shared types and helpers for sign-magnitude arithmetic blocks.
// Conversions work on a MAXW-bit word and take the live width as an argument.
package sm_arith_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  typedef logic [MAXW-1:0] word_t;

  function automatic word_t wmask(input int w);
    return {MAXW{1'b1}} >> (MAXW - w);
  endfunction

  function automatic logic sgn_of(input word_t v, input int w);
    return |(v & (word_t'(1) << (w - 1)));
  endfunction

  // Negative zero falls out as 0 since -0 == 0.
  function automatic word_t sm_to_c2(input word_t v, input int w);
    word_t m;
    word_t mag;
    m   = wmask(w);
    mag = v & (m >> 1);
    return sgn_of(v, w) ? ((-mag) & m) : mag;
  endfunction

  function automatic word_t c2_to_sm(input word_t v, input int w);
    word_t m;
    word_t mag;
    logic  s;
    m   = wmask(w);
    s   = sgn_of(v, w);
    mag = s ? ((-v) & m) : (v & m);
    return s ? (mag | (word_t'(1) << (w - 1))) : mag;
  endfunction

  function automatic bit sm_legal(input int w, input int d);
    return (w >= 2) && (w <= MAXW) && (d >= 1) &&
           (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/fac.sv
// Single-bit full adder cell.
module fac (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_digit.sv
// D-bit ripple-carry digit adder built from fac cells.
module rca_digit #(
  parameter int D = 4
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         c_in,
  output logic [D-1:0] z,
  output logic         c_out
);

  logic [D:0] c;

  assign c[0]  = c_in;
  assign c_out = c[D];

  for (genvar i = 0; i < D; i++) begin : g_bit
    fac u_fac (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (z[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/sm_addsub_serial.sv
// Digit-serial sign-magnitude add/sub, D bits per clock.
// Define SM_ADDSUB_SAT_EN to saturate z on overflow instead of zeroing it.
module sm_addsub_serial
  import sm_arith_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         c_out,
  output logic         ovr
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!sm_legal(W, D)) begin : g_bad_cfg
    $error("sm_addsub_serial: illegal W/D combination");
  end

  state_e         state_q, state_d;
  logic [W-1:0]   xs_q, xs_d;
  logic [W-1:0]   ys_q, ys_d;
  logic [W-1:0]   zs_q, zs_d;
  logic           cy_q, cy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           xsg_q, xsg_d;
  logic           ysg_q, ysg_d;
  logic [W-1:0]   z_q, z_d;
  logic           c_q, c_d;
  logic           ovr_q, ovr_d;
  logic           done_q, done_d;

  logic [W-1:0]   x_c, y_c, y_eff, zs_n;
  logic [D-1:0]   dsum;
  logic           dcy, raw_ovr, min_neg;

  rca_digit #(.D(D)) u_rca (
    .x     (xs_q[D-1:0]),
    .y     (ys_q[D-1:0]),
    .c_in  (cy_q),
    .z     (dsum),
    .c_out (dcy)
  );

  assign y_eff = {y[W-1] ^ op, y[W-2:0]};
  assign x_c   = W'(sm_to_c2(word_t'(x), W));
  assign y_c   = W'(sm_to_c2(word_t'(y_eff), W));

  // New digit enters at the top so the LSB digit ends up lowest.
  assign zs_n    = (zs_q >> D) | (W'(dsum) << (W - D));
  assign raw_ovr = (xsg_q == ysg_q) && (zs_n[W-1] != xsg_q);
  assign min_neg = (zs_n == {1'b1, {(W-1){1'b0}}});

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    zs_d    = zs_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    xsg_d   = xsg_q;
    ysg_d   = ysg_q;
    z_d     = z_q;
    c_d     = c_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = x_c;
          ys_d    = y_c;
          xsg_d   = x_c[W-1];
          ysg_d   = y_c[W-1];
          zs_d    = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        xs_d  = xs_q >> D;
        ys_d  = ys_q >> D;
        zs_d  = zs_n;
        cy_d  = dcy;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          c_d     = dcy;
          ovr_d   = raw_ovr | min_neg;
          if (raw_ovr | min_neg) begin
`ifdef SM_ADDSUB_SAT_EN
            z_d = {(raw_ovr ? xsg_q : 1'b1), {(W-1){1'b1}}};
`else
            z_d = '0;
`endif
          end else begin
            z_d = W'(c2_to_sm(word_t'(zs_n), W));
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      zs_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      xsg_q   <= 1'b0;
      ysg_q   <= 1'b0;
      z_q     <= '0;
      c_q     <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      zs_q    <= zs_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      xsg_q   <= xsg_d;
      ysg_q   <= ysg_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign z     = z_q;
  assign c_out = c_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_sm_addsub_serial.sv
// Self-checking bench for sm_addsub_serial (W=16, D=4).
// Build with SM_ADDSUB_SAT_EN to check the saturating variant.
module tb_sm_addsub_serial;

`ifdef SM_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        busy, done, c_out, ovr;
  logic [15:0] z;

  sm_addsub_serial #(.W(16), .D(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .c_out (c_out),
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        op;
    logic [15:0] z;
    logic        c;
    logic        ovr;
  } vec_t;

  typedef struct {
    logic [15:0] z;
    logic        c;
    logic        ovr;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic o);
    int          av, bv, s;
    logic [16:0] t;
    exp_t        e;
    av = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    bv = (b[15] ^ o) ? -int'(b[14:0]) : int'(b[14:0]);
    s  = av + bv;
    t  = {1'b0, 16'(av)} + {1'b0, 16'(bv)};
    e.c   = t[16];
    e.ovr = (s > 32767) || (s < -32767);
    if (e.ovr) e.z = SAT ? ((s < 0) ? 16'hFFFF : 16'h7FFF) : 16'h0000;
    else if (s < 0) e.z = {1'b1, 15'(-s)};
    else e.z = 16'(s);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (rst_b && done) begin
      exp_t e;
      done_cnt++;
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: z=%h with no pending op", z);
      end else begin
        e = sbq.pop_front();
        chk("z", 32'(z), 32'(e.z));
        chk("c_out", 32'(c_out), 32'(e.c));
        chk("ovr", 32'(ovr), 32'(e.ovr));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic o, input exp_t e);
    int lat;
    wait_idle();
    @(negedge clk);
    x = a; y = b; op = o; start = 1'b1;
    sbq.push_back(e);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) break;
    end
    chk("latency", 32'(lat), 32'd5);
    @(negedge clk);
    chk("done_fall", {30'd0, busy, done}, 32'd0);
  endtask

  vec_t tbl[10];
  exp_t e;
  int   d0, t;

  initial begin
    tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h8009, 1'b0, 16'h8004, 1'b0, 1'b0};
    tbl[2] = '{16'h0005, 16'h8009, 1'b1, 16'h000E, 1'b0, 1'b0};
    tbl[3] = '{16'h4E20, 16'h4E20, 1'b0,
               SAT ? 16'h7FFF : 16'h0000, 1'b0, 1'b1};
    tbl[4] = '{16'hC000, 16'hC000, 1'b0,
               SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h8005, 16'h8003, 1'b0, 16'h8008, 1'b1, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h0001, 1'b1, 16'h7FFE, 1'b1, 1'b0};
    tbl[8] = '{16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{16'h7FFF, 16'h0001, 1'b0,
               SAT ? 16'h7FFF : 16'h0000, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_state", {27'd0, busy, done, c_out, ovr, |z}, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {30'd0, busy, done}, 32'd0);

    foreach (tbl[i]) begin
      e = '{tbl[i].z, tbl[i].c, tbl[i].ovr};
      run_op(tbl[i].x, tbl[i].y, tbl[i].op, e);
    end

    for (int i = 0; i < 16; i++) begin
      logic [15:0] a, b;
      logic        o;
      a = 16'($urandom);
      b = 16'($urandom);
      o = 1'($urandom);
      run_op(a, b, o, model(a, b, o));
    end

    // A second start while busy must be dropped.
    wait_idle();
    @(negedge clk);
    x = 16'h1234; y = 16'h0101; op = 1'b0; start = 1'b1;
    sbq.push_back(model(16'h1234, 16'h0101, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 16'h7FFF; y = 16'h7FFF; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 3;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      t++;
    end
    chk("latency_ignored_start", 32'(t), 32'd5);
    @(negedge clk);
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("no_extra_done", 32'(done_cnt - d0), 32'd0);

    // Reset during the second ADD cycle discards the operation.
    @(negedge clk);
    x = 16'h0100; y = 16'h0200; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_outs", {28'd0, done, c_out, ovr, |z}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    run_op(16'h0100, 16'h0200, 1'b0, model(16'h0100, 16'h0200, 1'b0));

    // Start held high: next accept lands N+2 cycles after the first.
    wait_idle();
    @(negedge clk);
    x = 16'h0011; y = 16'h0022; op = 1'b0; start = 1'b1;
    sbq.push_back(model(16'h0011, 16'h0022, 1'b0));
    sbq.push_back(model(16'h8033, 16'h0004, 1'b1));
    @(negedge clk);
    x = 16'h8033; y = 16'h0004; op = 1'b1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      t++;
      if (t >= 2 && busy) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    chk("b2b_period", 32'(t), 32'd6);
    @(negedge clk);
    chk("b2b_idle", {30'd0, busy, done}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
